// File: rtl/sonic_vc_tx_pkt_arbiter.sv
// ---------------------------------------------------------------------------
// sonic_vc_tx_pkt_arbiter
//
// Packet-granular round-robin arbiter that shares one 133-bit Avalon-ST TX
// FIFO sink among NUM_CH virtual-channel packet sources. A grant is taken in
// IDLE (one bubble cycle), held from the accepted SOP beat through the
// accepted EOP beat, then released with the pointer moved past the owner.
//
// Ports:
//   wrclock, reset_n           clock, asynchronous active-low reset
//   ch_data/ch_empty           per-channel payload, channel i at slice i
//   ch_sop/ch_eop/ch_error     per-channel framing
//   ch_valid / ch_ready        per-channel handshake (ready latency 0)
//   src_*                      forwarded beat towards the TX FIFO sink
//   src_ready                  FIFO sink ready (ready latency 0)
//   cur_grant                  one-hot owner, 0 while idle
//   proto_err                  sticky: a stray non-SOP beat was drained
//
// Optional build macro SONIC_VC_TX_ARB_WDOG_EN adds:
//   wdog_limit[15:0] (in)      beat-gap limit, 0 disables the watchdog
//   wdog_fire        (out)     one-cycle pulse when the packet is cut off
// ---------------------------------------------------------------------------
module sonic_vc_tx_pkt_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 128,
    parameter int EMPTY_W = 2
) (
    input  logic                      wrclock,
    input  logic                      reset_n,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    input  logic [NUM_CH*EMPTY_W-1:0] ch_empty,
    input  logic [NUM_CH-1:0]         ch_sop,
    input  logic [NUM_CH-1:0]         ch_eop,
    input  logic [NUM_CH-1:0]         ch_error,
    input  logic [NUM_CH-1:0]         ch_valid,
    output logic [NUM_CH-1:0]         ch_ready,
    output logic [DATA_W-1:0]         src_data,
    output logic [EMPTY_W-1:0]        src_empty,
    output logic                      src_sop,
    output logic                      src_eop,
    output logic                      src_error,
    output logic                      src_valid,
    input  logic                      src_ready,
    output logic [NUM_CH-1:0]         cur_grant,
`ifdef SONIC_VC_TX_ARB_WDOG_EN
    input  logic [15:0]               wdog_limit,
    output logic                      wdog_fire,
`endif
    output logic                      proto_err
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_CH-1:0]  r_grant;
    logic [NUM_CH-1:0]  w_grant_nxt;
    logic [PTR_W-1:0]   r_owner;
    logic [PTR_W-1:0]   w_owner_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic               r_perr;
    logic               w_perr_nxt;

    logic [NUM_CH-1:0]  w_req;
    logic [PTR_W-1:0]   w_pick;
    logic               w_pick_vld;
    logic [NUM_CH-1:0]  w_pick_oh;
    logic [NUM_CH-1:0]  w_drain;
    logic [PTR_W-1:0]   w_ptr_inc;
    logic               w_acc;
    logic               w_close;
    logic               w_fire;

    assign w_req     = ch_valid & ch_sop;
    assign w_pick_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << w_pick;
    assign w_ptr_inc = (r_owner == PTR_W'(NUM_CH-1)) ? {PTR_W{1'b0}} : r_owner + PTR_W'(1);

    // Stray non-SOP beats on ungranted channels are swallowed; suppressed
    // while reset is held so every ready reads 0 during reset.
    assign w_drain = ch_valid & ~ch_sop & ~r_grant & {NUM_CH{reset_n}};

    // The owner's ready is src_ready (never its own valid), so acceptance
    // is simply owner valid and sink ready while transferring.
    assign w_acc   = (r_state == ST_XFER) && ch_valid[r_owner] && src_ready && !w_fire;
    assign w_close = (w_acc && ch_eop[r_owner]) || w_fire;

    assign cur_grant = r_grant;
    assign proto_err = r_perr;

`ifdef SONIC_VC_TX_ARB_WDOG_EN
    logic [15:0] r_gap;

    assign w_fire    = (r_state == ST_XFER) && (wdog_limit != 16'd0) && (r_gap == wdog_limit);
    assign wdog_fire = w_fire;

    // Beat-gap counter: counts owner-idle cycles while the sink could accept.
    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            r_gap <= 16'd0;
        end else if (r_state != ST_XFER) begin
            r_gap <= 16'd0;
        end else if (w_acc || w_fire) begin
            r_gap <= 16'd0;
        end else if (!ch_valid[r_owner] && src_ready) begin
            r_gap <= r_gap + 16'd1;
        end else begin
            r_gap <= r_gap;
        end
    end
`else
    assign w_fire = 1'b0;
`endif

    // Round-robin pick: first SOP requester at or after the pointer, wrapping.
    always_comb begin
        logic [PTR_W:0]   v_sum;
        logic [PTR_W-1:0] v_idx;
        logic             v_found;
        w_pick  = r_ptr;
        v_found = 1'b0;
        v_sum   = {(PTR_W+1){1'b0}};
        v_idx   = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            v_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (v_sum >= (PTR_W+1)'(NUM_CH)) begin
                v_sum = v_sum - (PTR_W+1)'(NUM_CH);
            end else begin
                v_sum = v_sum;
            end
            v_idx = v_sum[PTR_W-1:0];
            if (!v_found && w_req[v_idx]) begin
                w_pick  = v_idx;
                v_found = 1'b1;
            end else begin
                v_found = v_found;
            end
        end
        w_pick_vld = v_found;
    end

    // Next-state logic for the grant FSM, pointer and sticky error.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_perr_nxt  = r_perr | (|w_drain);
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_XFER;
                    w_grant_nxt = w_pick_oh;
                    w_owner_nxt = w_pick;
                end else begin
                    w_grant_nxt = {NUM_CH{1'b0}};
                end
            end
            ST_XFER: begin
                if (w_close) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = {NUM_CH{1'b0}};
                    w_ptr_nxt   = w_ptr_inc;
                end else begin
                    w_state_nxt = ST_XFER;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = {NUM_CH{1'b0}};
            end
        endcase
    end

    // State registers.
    always_ff @(posedge wrclock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= {NUM_CH{1'b0}};
            r_owner <= {PTR_W{1'b0}};
            r_ptr   <= {PTR_W{1'b0}};
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_perr  <= w_perr_nxt;
        end
    end

    // Datapath: mux the owner onto the sink; a watchdog cut-off substitutes
    // a zero-data terminating error beat and withholds the owner's ready.
    always_comb begin
        src_data  = {DATA_W{1'b0}};
        src_empty = {EMPTY_W{1'b0}};
        src_sop   = 1'b0;
        src_eop   = 1'b0;
        src_error = 1'b0;
        src_valid = 1'b0;
        ch_ready  = w_drain;
        if (r_state == ST_XFER) begin
            if (w_fire) begin
                src_valid = 1'b1;
                src_eop   = 1'b1;
                src_error = 1'b1;
            end else begin
                src_data          = ch_data[r_owner*DATA_W +: DATA_W];
                src_empty         = ch_empty[r_owner*EMPTY_W +: EMPTY_W];
                src_sop           = ch_sop[r_owner];
                src_eop           = ch_eop[r_owner];
                src_error         = ch_error[r_owner];
                src_valid         = ch_valid[r_owner];
                ch_ready[r_owner] = src_ready;
            end
        end else begin
            src_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_sonic_vc_tx_pkt_arbiter.sv
`define CHK(tag, o, e) begin checks++; if ((160'(o)) !== (160'(e))) begin errors++; $error("FAIL %s: observed %0h expected %0h", tag, 160'(o), 160'(e)); end end

module tb_sonic_vc_tx_pkt_arbiter;

    localparam int NUM_CH  = 4;
    localparam int DATA_W  = 128;
    localparam int EMPTY_W = 2;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [EMPTY_W-1:0] empty;
        logic               sop;
        logic               eop;
        logic               err;
    } beat_t;

    logic                      wrclock = 1'b0;
    logic                      reset_n = 1'b0;
    logic [NUM_CH*DATA_W-1:0]  ch_data  = '0;
    logic [NUM_CH*EMPTY_W-1:0] ch_empty = '0;
    logic [NUM_CH-1:0]         ch_sop   = '0;
    logic [NUM_CH-1:0]         ch_eop   = '0;
    logic [NUM_CH-1:0]         ch_error = '0;
    logic [NUM_CH-1:0]         ch_valid = '0;
    logic [NUM_CH-1:0]         ch_ready;
    logic [DATA_W-1:0]         src_data;
    logic [EMPTY_W-1:0]        src_empty;
    logic                      src_sop, src_eop, src_error, src_valid;
    logic                      src_ready = 1'b0;
    logic [NUM_CH-1:0]         cur_grant;
    logic                      proto_err;
`ifdef SONIC_VC_TX_ARB_WDOG_EN
    logic [15:0]               wdog_limit = 16'd0;
    logic                      wdog_fire;
`endif

    int    errors  = 0;
    int    checks  = 0;
    int    gap_pct = 0;
    beat_t chq[NUM_CH][$];
    beat_t expq[NUM_CH][$];

    sonic_vc_tx_pkt_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) dut (
        .wrclock(wrclock), .reset_n(reset_n),
        .ch_data(ch_data), .ch_empty(ch_empty), .ch_sop(ch_sop), .ch_eop(ch_eop),
        .ch_error(ch_error), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .src_data(src_data), .src_empty(src_empty), .src_sop(src_sop), .src_eop(src_eop),
        .src_error(src_error), .src_valid(src_valid), .src_ready(src_ready),
        .cur_grant(cur_grant),
`ifdef SONIC_VC_TX_ARB_WDOG_EN
        .wdog_limit(wdog_limit), .wdog_fire(wdog_fire),
`endif
        .proto_err(proto_err)
    );

    always #5 wrclock = ~wrclock;

    function automatic logic [DATA_W-1:0] mk_data(input int c, input int b);
        logic [31:0] w;
        w = 32'hA5A5_0000 ^ 32'(c * 256 + b);
        return {4{w}};
    endfunction

    // Source engine: present each channel's queue head; SOP heads are always valid.
    task automatic drive();
        for (int c = 0; c < NUM_CH; c++) begin
            beat_t b;
            logic  v;
            if (chq[c].size() > 0) begin
                b = chq[c][0];
                v = b.sop ? 1'b1 : (int'($urandom_range(99)) >= gap_pct);
            end else begin
                b = '0;
                v = 1'b0;
            end
            ch_data[c*DATA_W +: DATA_W]    = b.data;
            ch_empty[c*EMPTY_W +: EMPTY_W] = b.empty;
            ch_sop[c]   = b.sop;
            ch_eop[c]   = b.eop;
            ch_error[c] = b.err;
            ch_valid[c] = v;
        end
    endtask

    task automatic advance();
        logic [NUM_CH-1:0] acc;
        acc = ch_ready & ch_valid;
        @(posedge wrclock);
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc[c] && chq[c].size() > 0) void'(chq[c].pop_front());
        end
        @(negedge wrclock);
    endtask

    task automatic load_pkt(input int c, input int len, input int tag);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = mk_data(c, tag * 16 + i);
            b.empty = (i == len - 1) ? 2'(tag) : 2'd0;
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.err   = 1'b0;
            chq[c].push_back(b);
        end
    endtask

    task automatic do_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            chq[c].delete();
            expq[c].delete();
        end
        reset_n   = 1'b0;
        src_ready = 1'b1;
        gap_pct   = 0;
        drive();
        @(negedge wrclock);
        @(negedge wrclock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] eg;
        int         ech, eb, n, mptr, mown, left;
        beat_t      b, e;

        // Reset state
        drive();
        @(negedge wrclock);
        #1;
        `CHK("rst_grant", cur_grant, 4'b0000);
        `CHK("rst_perr", proto_err, 1'b0);
        `CHK("rst_valid", src_valid, 1'b0);
        `CHK("rst_ready", ch_ready, 4'b0000);
        checks++;
        if (cur_grant !== 4'b0000) begin
            errors++;
            $error("FAIL rst_grant_direct: observed %0h", cur_grant);
        end

        // Test 1: ch0 and ch2 three-beat packets, one bubble between them
        do_reset();
        load_pkt(0, 3, 1);
        load_pkt(2, 3, 1);
        for (int cyc = 0; cyc < 9; cyc++) begin
            drive();
            #1;
            eg  = (cyc >= 1 && cyc <= 3) ? 4'b0001 : (cyc >= 5 && cyc <= 7) ? 4'b0100 : 4'b0000;
            ech = (cyc < 4) ? 0 : 2;
            eb  = (cyc < 4) ? cyc - 1 : cyc - 5;
            `CHK("t1_grant", cur_grant, eg);
            `CHK("t1_valid", src_valid, (eg != 4'b0000));
            if (eg != 4'b0000) begin
                `CHK("t1_data", src_data, mk_data(ech, 16 + eb));
                `CHK("t1_sop", src_sop, (eb == 0));
                `CHK("t1_eop", src_eop, (eb == 2));
                if (eb == 2) `CHK("t1_empty", src_empty, 2'd1);
            end
            advance();
        end

        // Test 2: all channels stream single-beat packets; rotation 0,1,2,3,0,...
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NUM_CH; c++) load_pkt(c, 1, 2 + k);
        for (int cyc = 0; cyc < 17; cyc++) begin
            drive();
            #1;
            if (cyc % 2 == 1) begin
                n   = (cyc - 1) / 2;
                ech = n % NUM_CH;
                `CHK("t2_valid", src_valid, 1'b1);
                `CHK("t2_grant", cur_grant, 4'b0001 << ech);
                `CHK("t2_data", src_data, mk_data(ech, (2 + n / NUM_CH) * 16));
            end else begin
                `CHK("t2_bubble", src_valid, 1'b0);
                checks++;
                if (src_valid !== 1'b0) begin
                    errors++;
                    $error("FAIL t2_bubble_direct: cycle %0d src_valid=%b", cyc, src_valid);
                end
            end
            advance();
        end

        // Test 3: ch1 stalled by src_ready low for 10 cycles
        do_reset();
        load_pkt(1, 4, 5);
        drive(); #1;
        `CHK("t3_idle", cur_grant, 4'b0000);
        advance();
        drive(); #1;
        `CHK("t3_grant", cur_grant, 4'b0010);
        `CHK("t3_beat0", src_data, mk_data(1, 80));
        advance();
        load_pkt(0, 2, 6);
        load_pkt(2, 2, 6);
        src_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(); #1;
            `CHK("t3_hold_data", src_data, mk_data(1, 81));
            `CHK("t3_hold_valid", src_valid, 1'b1);
            `CHK("t3_hold_ready", ch_ready, 4'b0000);
            `CHK("t3_hold_grant", cur_grant, 4'b0010);
            advance();
        end
        src_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            drive(); #1;
            `CHK("t3_resume", src_data, mk_data(1, 80 + i));
            `CHK("t3_resume_rdy", ch_ready, 4'b0010);
            advance();
        end
        drive(); #1;
        `CHK("t3_gap", cur_grant, 4'b0000);
        advance();
        drive(); #1;
        `CHK("t3_next", cur_grant, 4'b0100);

        // SOP inside an open packet is forwarded and not flagged
        do_reset();
        b = '0; b.sop = 1'b1; b.data = mk_data(0, 200); chq[0].push_back(b);
        b.data = mk_data(0, 201); chq[0].push_back(b);
        b.sop = 1'b0; b.eop = 1'b1; b.data = mk_data(0, 202); chq[0].push_back(b);
        drive(); #1;
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(); #1;
            `CHK("t4a_sop", src_sop, (i < 2));
            `CHK("t4a_data", src_data, mk_data(0, 200 + i));
            advance();
        end
        drive(); #1;
        `CHK("t4a_perr", proto_err, 1'b0);
        `CHK("t4a_idle", cur_grant, 4'b0000);

        // Test 4: stray non-SOP beat on idle ch3 is drained and flagged
        do_reset();
        b = '0; b.eop = 1'b1; b.data = mk_data(3, 99); chq[3].push_back(b);
        drive(); #1;
        `CHK("t4_drain_rdy", ch_ready, 4'b1000);
        `CHK("t4_no_fwd", src_valid, 1'b0);
        `CHK("t4_perr_pre", proto_err, 1'b0);
        checks++;
        if (ch_ready !== 4'b1000) begin
            errors++;
            $error("FAIL t4_drain_direct: observed %0h", ch_ready);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(); #1;
            `CHK("t4_perr_sticky", proto_err, 1'b1);
            `CHK("t4_grant", cur_grant, 4'b0000);
            `CHK("t4_src", src_valid, 1'b0);
            advance();
        end

        // Test 5: reset mid-packet, then ch1 wins over ch3 (pointer back at 0)
        do_reset();
        load_pkt(0, 4, 7);
        drive(); #1; advance();
        drive(); #1; advance();
        drive(); #1;
        `CHK("t5_mid", src_data, mk_data(0, 113));
        reset_n = 1'b0;
        #1;
        `CHK("t5_rst_valid", src_valid, 1'b0);
        `CHK("t5_rst_grant", cur_grant, 4'b0000);
        `CHK("t5_rst_ready", ch_ready, 4'b0000);
        `CHK("t5_rst_sop", src_sop, 1'b0);
        chq[0].delete();
        advance();
        load_pkt(3, 1, 8);
        load_pkt(1, 1, 8);
        drive();
        reset_n = 1'b1;
        #1;
        `CHK("t5_idle", cur_grant, 4'b0000);
        advance();
        drive(); #1;
        `CHK("t5_first", cur_grant, 4'b0010);
        `CHK("t5_first_data", src_data, mk_data(1, 128));
        advance();
        drive(); #1; advance();
        drive(); #1;
        `CHK("t5_second", cur_grant, 4'b1000);
        `CHK("t5_perr", proto_err, 1'b0);
        advance();

`ifdef SONIC_VC_TX_ARB_WDOG_EN
        // Test 6: watchdog cuts off an owner that stops sending
        do_reset();
        wdog_limit = 16'd5;
        gap_pct    = 100;
        load_pkt(0, 3, 9);
        drive(); #1; advance();
        drive(); #1;
        `CHK("t6_sop", src_sop, 1'b1);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(); #1;
            `CHK("t6_quiet", wdog_fire, 1'b0);
            `CHK("t6_gap_valid", src_valid, 1'b0);
            advance();
        end
        drive(); #1;
        `CHK("t6_fire", wdog_fire, 1'b1);
        `CHK("t6_term", {src_valid, src_eop, src_error}, 3'b111);
        `CHK("t6_data", src_data, 128'd0);
        advance();
        drive(); #1;
        `CHK("t6_idle", cur_grant, 4'b0000);
        `CHK("t6_pulse", wdog_fire, 1'b0);
        wdog_limit = 16'd0;
`endif

        // Randomized traffic against a packet-level round-robin model
        do_reset();
        gap_pct = 25;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int p = 0; p < 6; p++) begin
                n = int'($urandom_range(4, 1));
                for (int i = 0; i < n; i++) begin
                    b.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
                    b.empty = 2'($urandom_range(3));
                    b.sop   = (i == 0);
                    b.eop   = (i == n - 1);
                    b.err   = (i == n - 1) ? 1'($urandom_range(1)) : 1'b0;
                    chq[c].push_back(b);
                    expq[c].push_back(b);
                end
            end
        end
        mptr = 0;
        mown = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            left = 0;
            for (int c = 0; c < NUM_CH; c++) left += expq[c].size();
            if (left == 0) break;
            src_ready = ($urandom_range(3) != 0);
            drive(); #1;
            `CHK("rnd_stray", ch_ready & ~cur_grant, 4'b0000);
            `CHK("rnd_idle_valid", src_valid & (cur_grant == 4'b0000), 1'b0);
            if (src_valid && src_ready) begin
                if (mown < 0) begin
                    for (int k = NUM_CH - 1; k >= 0; k--) begin
                        if (expq[(mptr + k) % NUM_CH].size() > 0) mown = (mptr + k) % NUM_CH;
                    end
                    `CHK("rnd_grant", cur_grant, 4'b0001 << mown);
                end
                if (mown >= 0) begin
                    e = expq[mown].pop_front();
                    `CHK("rnd_beat", {src_data, src_empty, src_sop, src_eop, src_error}, e);
                    if (e.eop) begin
                        mptr = (mown + 1) % NUM_CH;
                        mown = -1;
                    end
                end
            end
            advance();
        end
        left = 0;
        for (int c = 0; c < NUM_CH; c++) left += expq[c].size();
        `CHK("rnd_all_delivered", left, 0);
        `CHK("rnd_perr", proto_err, 1'b0);
        checks++;
        if (left != 0) begin
            errors++;
            $error("FAIL rnd_left_direct: %0d beats undelivered", left);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $error("FAIL rnd_perr_direct: proto_err=%b", proto_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
